// File: rtl/jtag_pkg.sv
// jtag_pkg: definitions shared by the JTAG host sequencer and the TAP.
//   - jtag_state_e : sequencer state encoding
//   - PRE_*_LEN    : TMS prefix lengths from Run-Test/Idle to Shift-DR/IR
//   - TLR_LEN      : number of TMS=1 clocks that force Test-Logic-Reset
//   - IR_*         : 4-bit instruction opcodes understood by the TAP
package jtag_pkg;

  typedef enum logic [2:0] {
    ST_RESET_SEQ = 3'd0,
    ST_IDLE      = 3'd1,
    ST_PRE       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_UPD       = 3'd4
  } jtag_state_e;

  localparam int PRE_DR_LEN = 3;  // TMS 1,0,0   : RTI -> Select-DR -> Capture-DR -> Shift-DR
  localparam int PRE_IR_LEN = 4;  // TMS 1,1,0,0 : RTI -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
  localparam int TLR_LEN    = 5;  // five TMS=1 clocks reach Test-Logic-Reset from any state

  localparam logic [3:0] IR_BYPASS   = 4'hF;
  localparam logic [3:0] IR_SAMPLE   = 4'h1;
  localparam logic [3:0] IR_EXTEST   = 4'h2;
  localparam logic [3:0] IR_INTEST   = 4'h3;
  localparam logic [3:0] IR_RUNBIST  = 4'h4;
  localparam logic [3:0] IR_CLAMP    = 4'h5;
  localparam logic [3:0] IR_IDCODE   = 4'h7;
  localparam logic [3:0] IR_USERCODE = 4'h8;
  localparam logic [3:0] IR_HIGHZ    = 4'h9;

endpackage

// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG sequencer driving a TAP's TMS/TDI and capturing TDO.
// Executes one command at a time: TAP reset, IR scan or DR scan. Scans start and
// end in Run-Test/Idle; data is shifted LSB first.
// Ports:
//   TCK, TRST            clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_reset, cmd_ir    command kind (reset overrides ir)
//   cmd_len, cmd_data    scan length (0 -> 1, clamped to MAX_LEN) and TDI bits
//   rsp_valid, rsp_data  one-cycle completion pulse and captured TDO bits
//   TMS, TDI, TDO        TAP pins (TMS/TDI registered)
module jtag_master
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_reset,
  input  logic               cmd_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  // The counter also walks the 5-clock reset sequence, so it needs at least 3 bits.
  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  jtag_state_e        r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_ir, w_ir_next;
  logic [CNT_W-1:0]   r_len, w_len_next;
  logic [MAX_LEN-1:0] r_data, w_data_next;
  logic [MAX_LEN-1:0] r_rsp, w_rsp_next;
  logic               r_tms, w_tms_next;
  logic               r_tdi, w_tdi_next;
  logic               r_ready, w_ready_next;
  logic               r_rsp_valid, w_rsp_valid_next;

  logic               w_accept;
  logic [LEN_W-1:0]   w_len_clamped;
  logic [CNT_W-1:0]   w_pre_last;
  logic [CNT_W-1:0]   w_pre_ones_next;
  logic [IDX_W-1:0]   w_bit;
  logic [IDX_W-1:0]   w_bit_next;

  assign w_accept      = r_ready && cmd_valid;
  assign w_len_clamped = (cmd_len == '0) ? LEN_W'(1) :
                         (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign w_pre_last    = r_ir ? CNT_W'(PRE_IR_LEN - 1) : CNT_W'(PRE_DR_LEN - 1);
  assign w_bit         = r_cnt[IDX_W-1:0];
  assign w_bit_next    = w_cnt_next[IDX_W-1:0];

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_ir_next        = r_ir;
    w_len_next       = r_len;
    w_data_next      = r_data;
    w_rsp_next       = r_rsp;
    w_tms_next       = 1'b1;
    w_tdi_next       = 1'b0;
    w_pre_ones_next  = '0;

    case (r_state)
      ST_RESET_SEQ: begin
        if (r_cnt == CNT_W'(TLR_LEN - 1)) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_next = '0;
          w_rsp_next = '0;
          if (cmd_reset) begin
            w_state_next = ST_RESET_SEQ;
          end else begin
            w_state_next = ST_PRE;
            w_ir_next    = cmd_ir;
            w_len_next   = CNT_W'(w_len_clamped);
            w_data_next  = cmd_data;
          end
        end
      end
      ST_PRE: begin
        if (r_cnt == w_pre_last) begin
          w_state_next = ST_SHIFT;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        // TDO of the bit currently presented is taken at the edge ending this cycle.
        w_rsp_next[w_bit] = TDO;
        if (r_cnt == r_len - CNT_W'(1)) begin
          w_state_next = ST_UPD;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_UPD: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = ST_RESET_SEQ;
        w_cnt_next   = '0;
      end
    endcase

    // Pin values are registered, so they are derived from the state being entered.
    // Both prefixes are a run of TMS=1 followed by exactly two TMS=0 clocks.
    w_pre_ones_next = w_ir_next ? CNT_W'(PRE_IR_LEN - 2) : CNT_W'(PRE_DR_LEN - 2);
    case (w_state_next)
      ST_RESET_SEQ: w_tms_next = 1'b1;
      ST_IDLE:      w_tms_next = 1'b0;
      ST_PRE:       w_tms_next = (w_cnt_next < w_pre_ones_next);
      ST_SHIFT: begin
        w_tdi_next = w_data_next[w_bit_next];
        w_tms_next = (w_cnt_next == w_len_next - CNT_W'(1));
      end
      ST_UPD:       w_tms_next = 1'b1;
      default:      w_tms_next = 1'b1;
    endcase

    w_ready_next     = (w_state_next == ST_IDLE);
    w_rsp_valid_next = (r_state == ST_UPD);
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      r_state     <= ST_RESET_SEQ;
      r_cnt       <= '0;
      r_ir        <= 1'b0;
      r_len       <= '0;
      r_data      <= '0;
      r_rsp       <= '0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_ir        <= w_ir_next;
      r_len       <= w_len_next;
      r_data      <= w_data_next;
      r_rsp       <= w_rsp_next;
      r_tms       <= w_tms_next;
      r_tdi       <= w_tdi_next;
      r_ready     <= w_ready_next;
      r_rsp_valid <= w_rsp_valid_next;
    end
  end

  assign TMS       = r_tms;
  assign TDI       = r_tdi;
  assign cmd_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp;

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: drives jtag_master against a small behavioural TAP and checks
// pin sequences, responses (via a scoreboard) and reset behaviour.
module tb_jtag_master;
  import jtag_pkg::*;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam logic [31:0] IDCODE_VAL = 32'h1234_50F1;

  logic               TCK = 1'b0;
  logic               TRST = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_reset = 1'b0;
  logic               cmd_ir = 1'b0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               cmd_ready;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               TMS;
  logic               TDI;
  logic               TDO;

  jtag_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .TCK(TCK), .TRST(TRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_reset(cmd_reset), .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 TCK = ~TCK;

  int cyc = 0;
  always @(posedge TCK) cyc <= cyc + 1;

  // ---------------- behavioural TAP ----------------
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
  } tap_e;

  tap_e        t_state;
  logic [3:0]  t_ir, t_irsr;
  logic [31:0] t_idsr;
  logic        t_byp;

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    tap_e n;
    case (s)
      T_TLR:   n = tms ? T_TLR   : T_RTI;
      T_RTI:   n = tms ? T_SELDR : T_RTI;
      T_SELDR: n = tms ? T_SELIR : T_CAPDR;
      T_CAPDR: n = tms ? T_EX1DR : T_SHDR;
      T_SHDR:  n = tms ? T_EX1DR : T_SHDR;
      T_EX1DR: n = tms ? T_UPDR  : T_PADR;
      T_PADR:  n = tms ? T_EX2DR : T_PADR;
      T_EX2DR: n = tms ? T_UPDR  : T_SHDR;
      T_UPDR:  n = tms ? T_SELDR : T_RTI;
      T_SELIR: n = tms ? T_TLR   : T_CAPIR;
      T_CAPIR: n = tms ? T_EX1IR : T_SHIR;
      T_SHIR:  n = tms ? T_EX1IR : T_SHIR;
      T_EX1IR: n = tms ? T_UPIR  : T_PAIR;
      T_PAIR:  n = tms ? T_EX2IR : T_PAIR;
      T_EX2IR: n = tms ? T_UPIR  : T_SHIR;
      T_UPIR:  n = tms ? T_SELDR : T_RTI;
      default: n = T_TLR;
    endcase
    return n;
  endfunction

  always @(posedge TCK) begin
    if (TRST) begin
      t_state <= T_TLR;
      t_ir    <= IR_IDCODE;
      t_irsr  <= '0;
      t_idsr  <= '0;
      t_byp   <= 1'b0;
    end else begin
      case (t_state)
        T_TLR:   t_ir <= IR_IDCODE;
        T_CAPIR: t_irsr <= 4'b0101;
        T_SHIR:  t_irsr <= {TDI, t_irsr[3:1]};
        T_UPIR:  t_ir <= t_irsr;
        T_CAPDR: begin t_idsr <= IDCODE_VAL; t_byp <= 1'b0; end
        T_SHDR:  if (t_ir == IR_IDCODE) t_idsr <= {TDI, t_idsr[31:1]}; else t_byp <= TDI;
        default: ;
      endcase
      t_state <= tap_next(t_state, TMS);
    end
  end

  assign TDO = (t_state == T_SHIR) ? t_irsr[0] :
               (t_state == T_SHDR) ? ((t_ir == IR_IDCODE) ? t_idsr[0] : t_byp) : 1'b0;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   n_rsp = 0;

  always @(negedge TCK) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        check("rsp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        $display("rsp %0d: data=%04h latency=%0d", n_rsp, rsp_data, cyc - mon_e.acc);
        n_rsp++;
      end
    end
  end

  // Called just after a negedge; returns just after the accepting posedge.
  task automatic accept_cmd(input logic rst, input logic ir, input logic [LEN_W-1:0] len,
                            input logic [15:0] data, input bit push,
                            input logic [15:0] exp_data, input int exp_lat, output int acc);
    int budget = 200;
    cmd_reset = rst; cmd_ir = ir; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && budget > 0) begin
      @(negedge TCK);
      budget--;
    end
    acc = -1;
    if (budget == 0) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      acc = cyc + 1;
      @(posedge TCK);
      if (push) sb.push_back('{exp_data, acc, exp_lat});
      $display("cmd: reset=%0b ir=%0b len=%0d data=%04h accepted at cycle %0d", rst, ir, len, data, acc);
    end
  endtask

  // Returns one cycle after the last response, when the TAP is back in Run-Test/Idle.
  task automatic wait_idle();
    int budget = 100;
    while (!(sb.size() == 0 && cmd_ready === 1'b1) && budget > 0) begin
      @(negedge TCK);
      budget--;
    end
    if (budget == 0) check("idle_timeout", 32'd0, 32'd1);
    @(negedge TCK);
  endtask

  // Called at the negedge where TRST is dropped.
  task automatic reset_recovery(input string tag);
    for (int k = 1; k <= 5; k++) begin
      @(negedge TCK);
      if (k < 5) begin
        check({tag, "_tms_high"}, 32'(TMS), 32'd1);
        check({tag, "_ready_low"}, 32'(cmd_ready), 32'd0);
      end else begin
        check({tag, "_ready_high"}, 32'(cmd_ready), 32'd1);
        check({tag, "_tms_rti"}, 32'(TMS), 32'd0);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tms"}, 32'(TMS), 32'd1);
    check({tag, "_tdi"}, 32'(TDI), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
  endtask

  typedef struct {
    logic             ir;
    logic [LEN_W-1:0] len;
    logic [15:0]      data;
    logic [15:0]      rsp;
    int               lat;
    logic [3:0]       ir_after;
  } vec_t;
  vec_t vecs[12];

  initial begin
    int acc, acc1, acc2;
    logic [0:9] exp_tms;
    logic [0:9] exp_tdi;

    vecs[0]  = '{1'b0, 5'd8,  16'h0000, 16'h00F1, 12, IR_IDCODE};
    vecs[1]  = '{1'b0, 5'd16, 16'hFFFF, 16'h50F1, 20, IR_IDCODE};
    vecs[2]  = '{1'b1, 5'd4,  16'h000F, 16'h0005,  9, IR_BYPASS};
    vecs[3]  = '{1'b0, 5'd9,  16'h01AB, 16'h0156, 13, IR_BYPASS};
    vecs[4]  = '{1'b0, 5'd0,  16'h0001, 16'h0000,  5, IR_BYPASS};
    vecs[5]  = '{1'b0, 5'd17, 16'hFFFF, 16'hFFFE, 20, IR_BYPASS};
    vecs[6]  = '{1'b0, 5'd31, 16'h8001, 16'h0002, 20, IR_BYPASS};
    vecs[7]  = '{1'b1, 5'd4,  16'hFFF7, 16'h0005,  9, IR_IDCODE};
    vecs[8]  = '{1'b0, 5'd1,  16'h0000, 16'h0001,  5, IR_IDCODE};
    vecs[9]  = '{1'b1, 5'd4,  16'h0003, 16'h0005,  9, IR_INTEST};
    vecs[10] = '{1'b0, 5'd3,  16'h0007, 16'h0006,  7, IR_INTEST};
    vecs[11] = '{1'b1, 5'd4,  16'h0007, 16'h0005,  9, IR_IDCODE};

    // Power-on reset and recovery
    repeat (3) @(posedge TCK);
    @(negedge TCK);
    check_reset_values("por");
    TRST = 1'b0;
    reset_recovery("por");

    // IR scan of IDCODE with full pin trace
    exp_tms = 10'b1100000110;
    exp_tdi = 10'b0000111000;
    accept_cmd(1'b0, 1'b1, 5'd4, 16'h0007, 1'b1, 16'h0005, 9, acc);
    for (int i = 0; i < 10; i++) begin
      @(negedge TCK);
      if (i == 0) cmd_valid = 1'b0;
      check($sformatf("ir_trace_tms%0d", i), 32'(TMS), 32'(exp_tms[i]));
      check($sformatf("ir_trace_tdi%0d", i), 32'(TDI), 32'(exp_tdi[i]));
    end
    wait_idle();
    check("ir_trace_tap_ir", 32'(t_ir), 32'(IR_IDCODE));

    // Table of scans
    for (int i = 0; i < 12; i++) begin
      accept_cmd(1'b0, vecs[i].ir, vecs[i].len, vecs[i].data, 1'b1, vecs[i].rsp, vecs[i].lat, acc);
      @(negedge TCK);
      cmd_valid = 1'b0;
      wait_idle();
      check($sformatf("vec%0d_tap_rti", i), 32'(t_state), 32'(T_RTI));
      check($sformatf("vec%0d_tap_ir", i), 32'(t_ir), 32'(vecs[i].ir_after));
    end

    // Back-to-back DR scans with cmd_valid held high
    accept_cmd(1'b0, 1'b0, 5'd2, 16'h0000, 1'b1, 16'h0001, 6, acc1);
    @(negedge TCK);
    cmd_len = 5'd3;
    for (int b = 0; b < 50 && cmd_ready !== 1'b1; b++) @(negedge TCK);
    check("b2b_rsp_valid_at_accept", 32'(rsp_valid), 32'd1);
    check("b2b_gap_tms", 32'(TMS), 32'd0);
    accept_cmd(1'b0, 1'b0, 5'd3, 16'h0000, 1'b1, 16'h0001, 7, acc2);
    check("b2b_accept_spacing", 32'(acc2 - acc1), 32'd7);
    @(negedge TCK);
    cmd_valid = 1'b0;
    check("b2b_second_pre_tms", 32'(TMS), 32'd1);
    wait_idle();

    // TRST during SHIFT bit 3 of a len=8 DR scan
    accept_cmd(1'b0, 1'b0, 5'd8, 16'h0008, 1'b0, 16'h0000, 0, acc);
    for (int k = 0; k < 7; k++) begin
      @(negedge TCK);
      if (k == 0) cmd_valid = 1'b0;
      if (k == 6) begin
        check("abort_shift3_tdi", 32'(TDI), 32'd1);
        check("abort_shift3_tms", 32'(TMS), 32'd0);
        TRST = 1'b1;
      end
    end
    @(negedge TCK);
    check_reset_values("abort");
    TRST = 1'b0;
    reset_recovery("abort");

    // Load BYPASS, then a TAP reset command must restore IDCODE
    accept_cmd(1'b0, 1'b1, 5'd4, 16'h000F, 1'b1, 16'h0005, 9, acc);
    @(negedge TCK);
    cmd_valid = 1'b0;
    wait_idle();
    check("pre_reset_tap_ir", 32'(t_ir), 32'(IR_BYPASS));
    accept_cmd(1'b1, 1'b1, 5'd4, 16'h0007, 1'b0, 16'h0000, 0, acc);
    for (int k = 0; k < 6; k++) begin
      @(negedge TCK);
      if (k == 0) begin cmd_valid = 1'b0; cmd_reset = 1'b0; end
      if (k < 5) begin
        check($sformatf("cmdrst_tms%0d", k), 32'(TMS), 32'd1);
        check($sformatf("cmdrst_ready%0d", k), 32'(cmd_ready), 32'd0);
      end else begin
        check("cmdrst_tms_rti", 32'(TMS), 32'd0);
        check("cmdrst_ready", 32'(cmd_ready), 32'd1);
        check("cmdrst_tap_tlr", 32'(t_state), 32'(T_TLR));
      end
    end
    @(negedge TCK);
    check("cmdrst_tap_ir", 32'(t_ir), 32'(IR_IDCODE));
    check("cmdrst_tap_rti", 32'(t_state), 32'(T_RTI));

    repeat (5) @(negedge TCK);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
